// File: rtl/rc_settle_monitor.sv
// rc_settle_monitor: watches a fixed-point RC response and reports whether it
// stays within TOL of TARGET for HOLD_CYCLES consecutive samples before TIMEOUT.
module rc_settle_monitor #(
   parameter int WIDTH       = 25,
   parameter int EXPONENT    = -20,
   parameter int TARGET      = 1048576,
   parameter int TOL         = 10486,
   parameter int HOLD_CYCLES = 8,
   parameter int TIMEOUT     = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] v_out,
   output logic                    busy,
   output logic                    done,
   output logic                    settled,
   output logic                    timed_out,
   output logic [15:0]             settle_cycles,
   output logic signed [WIDTH-1:0] peak
);

   // Raw values must map to a real that a double can hold, and the counters
   // are sized for the documented ranges.
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || TIMEOUT < 1 || TIMEOUT > 65534 ||
       TOL < 0 || EXPONENT < -1000 || EXPONENT > 1000) begin : g_param_check
      $error("rc_settle_monitor: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, TRACK, HOLD, DONE} state_t;

   localparam logic signed [WIDTH:0] TARGET_X = (WIDTH+1)'(TARGET);
   localparam logic [WIDTH:0]        TOL_X    = (WIDTH+1)'(TOL);
   localparam logic [15:0]           LAST_N   = 16'(TIMEOUT - 1);
   localparam logic [7:0]            HOLD_X   = 8'(HOLD_CYCLES);
   localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t       state;
   logic [15:0]  n;
   logic [15:0]  cand;
   logic [7:0]   run;

   logic signed [WIDTH:0] diff;
   logic [WIDTH:0]        mag;
   logic                  in_band;
   logic                  settle_now;
   logic [15:0]           settle_idx;

   // One extra bit keeps v_out - TARGET and its magnitude free of wrap.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      diff       = {v_out[WIDTH-1], v_out} - TARGET_X;
      mag        = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      in_band    = (mag <= TOL_X);
      settle_now = 1'b0;
      settle_idx = cand;
      if (state == TRACK) begin
         settle_now = in_band && (HOLD_CYCLES == 1);
         settle_idx = n;
      end else if (state == HOLD) begin
         settle_now = in_band && ((run + 8'd1) == HOLD_X);
      end
   end

   // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         n             <= '0;
         cand          <= '0;
         run           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         settled       <= 1'b0;
         timed_out     <= 1'b0;
         settle_cycles <= '0;
         peak          <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= TRACK;
                  n             <= '0;
                  cand          <= '0;
                  run           <= '0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  settled       <= 1'b0;
                  timed_out     <= 1'b0;
                  settle_cycles <= '0;
                  peak          <= MOST_NEG;
               end
            end
            TRACK, HOLD: begin
               n <= n + 16'd1;
               if (v_out > peak) peak <= v_out;
               // Settling is checked before the timeout so a tie on the last sample settles.
               if (settle_now) begin
                  state         <= DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  settled       <= 1'b1;
                  settle_cycles <= settle_idx;
               end else if (n == LAST_N) begin
                  state         <= DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  timed_out     <= 1'b1;
                  settle_cycles <= 16'hFFFF;
               end else if (in_band) begin
                  if (state == TRACK) begin
                     state <= HOLD;
                     run   <= 8'd1;
                     cand  <= n;
                  end else begin
                     run <= run + 8'd1;
                  end
               end else begin
                  state <= TRACK;
                  run   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
